// File: rtl/bridge_rr_arbiter_resp_if.sv
// Bundle of requester-side and bridge-side signals for bridge_rr_arbiter_resp.
//   slave  : the arbiter's view (takes channel requests and bridge responses)
//   master : the surrounding logic's view (drives requests, grant, responses)
// Per-channel fields are packed [N_CH-1:0][W-1:0], so channel k sits at
// bits [k*W +: W] of the flattened vector.
interface bridge_rr_arbiter_resp_if #(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 20,
  parameter int MAX_OUTST  = 4
);
  // requester channels
  logic [N_CH-1:0]                 data_req_i;
  logic [N_CH-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_CH-1:0]                 data_wen_i;
  logic [N_CH-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_CH-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_CH-1:0][ID_WIDTH-1:0]   data_ID_i;
  logic [N_CH-1:0]                 data_gnt_o;
  // merged bridge master port
  logic                            data_req_o;
  logic [ADDR_WIDTH-1:0]           data_add_o;
  logic                            data_wen_o;
  logic [DATA_WIDTH-1:0]           data_wdata_o;
  logic [BE_WIDTH-1:0]             data_be_o;
  logic [ID_WIDTH-1:0]             data_ID_o;
  logic                            data_gnt_i;
  // responses
  logic                            r_valid_i;
  logic [DATA_WIDTH-1:0]           r_rdata_i;
  logic [N_CH-1:0]                 r_valid_o;
  logic [DATA_WIDTH-1:0]           r_rdata_o;
  // status
  logic [$clog2(MAX_OUTST+1)-1:0]  outst_o;
  logic                            err_o;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_i, r_valid_i, r_rdata_i,
    output data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    output data_ID_o, r_valid_o, r_rdata_o, outst_o, err_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_i, r_valid_i, r_rdata_i,
    input  data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    input  data_ID_o, r_valid_o, r_rdata_o, outst_o, err_o
  );
endinterface

// File: rtl/bridge_rr_arbiter_resp.sv
// N-channel round-robin request arbiter with in-order response routing.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - bridge_rr_arbiter_resp_if.slave: channel requests/grants, merged
//          bridge request, response steering, outstanding count, sticky error
// Every handshake pushes the winning channel index into a small FIFO; each
// bridge response pops the head and is steered to that channel.

// Per-channel grant / response-valid decode.
module bridge_rr_arbiter_resp_lane #(
  parameter int RR_W = 2,
  parameter int LANE = 0
) (
  input  logic [RR_W-1:0] winner,
  input  logic [RR_W-1:0] head,
  input  logic            hs,
  input  logic            pop,
  output logic            gnt,
  output logic            rvld
);
  assign gnt  = hs  & (winner == RR_W'(LANE));
  assign rvld = pop & (head   == RR_W'(LANE));
endmodule

module bridge_rr_arbiter_resp #(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 20,
  parameter int MAX_OUTST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bridge_rr_arbiter_resp_if.slave bus
);
  localparam int RR_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = $clog2(MAX_OUTST+1);

  logic [RR_W-1:0]  rr_q, winner, head;
  logic [RR_W:0]    idx;
  logic [RR_W-1:0]  fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             full, hs, pop, underflow;

  // Scan rr_q, rr_q+1, ... backwards so the lowest offset with a request wins.
  always_comb begin
    winner = rr_q;
    idx    = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + (RR_W+1)'(i);
      if (idx >= (RR_W+1)'(N_CH)) idx = idx - (RR_W+1)'(N_CH);
      if (bus.data_req_i[idx[RR_W-1:0]]) winner = idx[RR_W-1:0];
    end
  end

  // Full depends only on registered count, so r_valid_i never reaches data_req_o.
  assign full      = (cnt_q == CNT_W'(MAX_OUTST));
  assign hs        = bus.data_req_o & bus.data_gnt_i;
  assign pop       = bus.r_valid_i & (cnt_q != '0);
  assign underflow = bus.r_valid_i & (cnt_q == '0);
  assign head      = fifo_q[rp_q];

  assign bus.data_req_o   = (|bus.data_req_i) & ~full;
  assign bus.data_add_o   = bus.data_add_i[winner];
  assign bus.data_wen_o   = bus.data_wen_i[winner];
  assign bus.data_wdata_o = bus.data_wdata_i[winner];
  assign bus.data_be_o    = bus.data_be_i[winner];
  assign bus.data_ID_o    = bus.data_ID_i[winner];
  assign bus.r_rdata_o    = bus.r_rdata_i;
  assign bus.outst_o      = cnt_q;
  assign bus.err_o        = err_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    bridge_rr_arbiter_resp_lane #(.RR_W(RR_W), .LANE(k)) u_lane (
      .winner (winner),
      .head   (head),
      .hs     (hs),
      .pop    (pop),
      .gnt    (bus.data_gnt_o[k]),
      .rvld   (bus.r_valid_o[k])
    );
  end

  // FIFO storage needs no reset: entries are only read when count != 0.
  always_ff @(posedge clk) begin
    if (hs) fifo_q[wp_q] <= winner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (hs) begin
        rr_q <= (winner == RR_W'(N_CH-1)) ? '0 : winner + 1'b1;
        wp_q <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      case ({hs, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (underflow) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bridge_rr_arbiter_resp.sv
module tb_bridge_rr_arbiter_resp;
  localparam int N = 4, AW = 32, DW = 32, BW = 4, IW = 20, MO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bridge_rr_arbiter_resp_if #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BE_WIDTH(BW), .ID_WIDTH(IW), .MAX_OUTST(MO)) bus ();

  bridge_rr_arbiter_resp #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BE_WIDTH(BW), .ID_WIDTH(IW), .MAX_OUTST(MO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // reference model: rotating priority pointer, queue of granted channels
  int m_rr = 0;
  int m_q[$];
  bit m_err = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int i = 0; i < N; i++)
      if (bus.data_req_i[(m_rr + i) % N]) return (m_rr + i) % N;
    return m_rr;
  endfunction

  always @(posedge clk) begin : model
    int w;
    bit hs, pop;
    w   = m_winner();
    hs  = (|bus.data_req_i) && (m_q.size() < MO) && bus.data_gnt_i;
    pop = bus.r_valid_i && (m_q.size() != 0);
    if (rst) begin
      m_rr = 0;
      m_q.delete();
      m_err = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(w);
        m_rr = (w + 1) % N;
      end
      if (bus.r_valid_i && !pop) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    int w;
    bit req;
    logic [N-1:0] eg, ev;
    if (chk_en) begin
      w   = m_winner();
      req = (|bus.data_req_i) && (m_q.size() != MO);
      eg  = '0;
      if (req && bus.data_gnt_i) eg[w] = 1'b1;
      ev  = '0;
      if (bus.r_valid_i && m_q.size() != 0) ev[m_q[0]] = 1'b1;
      chk("m_req_o",   64'(bus.data_req_o),   64'(req));
      chk("m_gnt_o",   64'(bus.data_gnt_o),   64'(eg));
      chk("m_add_o",   64'(bus.data_add_o),   64'(bus.data_add_i[w]));
      chk("m_wen_o",   64'(bus.data_wen_o),   64'(bus.data_wen_i[w]));
      chk("m_wdata_o", 64'(bus.data_wdata_o), 64'(bus.data_wdata_i[w]));
      chk("m_be_o",    64'(bus.data_be_o),    64'(bus.data_be_i[w]));
      chk("m_id_o",    64'(bus.data_ID_o),    64'(bus.data_ID_i[w]));
      chk("m_rvalid",  64'(bus.r_valid_o),    64'(ev));
      chk("m_rdata",   64'(bus.r_rdata_o),    64'(bus.r_rdata_i));
      chk("m_outst",   64'(bus.outst_o),      64'(m_q.size()));
      chk("m_err",     64'(bus.err_o),        64'(m_err));
    end
  end

  // advance one cycle, drive new inputs just after the edge, let them settle
  task automatic cyc(input logic r, input logic [N-1:0] req, input logic g,
                     input logic rv, input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    rst            = r;
    bus.data_req_i = req;
    bus.data_gnt_i = g;
    bus.r_valid_i  = rv;
    bus.r_rdata_i  = rd;
    #1;
  endtask

  initial begin
    int seq_rr[4];
    int seq_full[4];
    seq_rr   = '{1, 3, 1, 3};
    seq_full = '{3, 0, 1, 2};
    for (int k = 0; k < N; k++) begin
      bus.data_add_i[k]   = 32'h1000_0000 + 32'(k * 16);
      bus.data_wdata_i[k] = 32'hA000_0000 + 32'(k);
      bus.data_be_i[k]    = BW'(k + 1);
      bus.data_ID_i[k]    = IW'(k + 'h100);
    end
    bus.data_wen_i = 4'b0101;
    rst = 1'b1; bus.data_req_i = 4'b1111; bus.data_gnt_i = 1'b0;
    bus.r_valid_i = 1'b0; bus.r_rdata_i = '0;

    // reset
    cyc(1, 4'b1111, 0, 0, 0);
    cyc(1, 4'b1111, 0, 0, 0);
    chk("rst_gnt",   64'(bus.data_gnt_o), 64'h0);
    chk("rst_outst", 64'(bus.outst_o),    64'h0);
    chk("rst_err",   64'(bus.err_o),      64'h0);
    chk("rst_req",   64'(bus.data_req_o), 64'h1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b1111, 1, 0, 0);
      chk("rst_order_gnt", 64'(bus.data_gnt_o), 64'(1 << i));
    end
    cyc(0, 0, 0, 0, 0);
    chk("fill_outst", 64'(bus.outst_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 32'h5000 + 32'(i));
      chk("drain_rvalid", 64'(bus.r_valid_o), 64'(1 << i));
    end
    cyc(0, 0, 0, 0, 0);
    chk("drain_outst", 64'(bus.outst_o), 64'h0);

    // round robin between ch1 and ch3
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b1010, 1, 0, 0);
      chk("rr_gnt",  64'(bus.data_gnt_o), 64'(1 << seq_rr[i]));
      chk("rr_addr", 64'(bus.data_add_o), 64'(32'h1000_0000 + 32'(seq_rr[i] * 16)));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 32'h6000 + 32'(i));
      chk("rr_rvalid", 64'(bus.r_valid_o), 64'(1 << seq_rr[i]));
    end

    // backpressure on ch2
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b0100, 0, 0, 0);
      chk("bp_req",   64'(bus.data_req_o), 64'h1);
      chk("bp_gnt",   64'(bus.data_gnt_o), 64'h0);
      chk("bp_outst", 64'(bus.outst_o),    64'h0);
    end
    cyc(0, 4'b0100, 1, 0, 0);
    chk("bp_gnt2", 64'(bus.data_gnt_o), 64'b0100);
    cyc(0, 0, 0, 0, 0);
    chk("bp_outst1", 64'(bus.outst_o), 64'h1);
    cyc(0, 0, 0, 1, 32'h7000);
    chk("bp_rvalid", 64'(bus.r_valid_o), 64'b0100);

    // full stall
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b1111, 1, 0, 0);
      chk("full_gnt", 64'(bus.data_gnt_o), 64'(1 << seq_full[i]));
    end
    cyc(0, 4'b1111, 1, 0, 0);
    chk("full_outst", 64'(bus.outst_o),    64'd4);
    chk("full_req",   64'(bus.data_req_o), 64'h0);
    chk("full_gnt0",  64'(bus.data_gnt_o), 64'h0);
    cyc(0, 4'b1111, 1, 1, 32'hCAFE);
    chk("full_rvalid", 64'(bus.r_valid_o),  64'b1000);
    chk("full_req2",   64'(bus.data_req_o), 64'h0);
    cyc(0, 4'b1111, 1, 0, 0);
    chk("full_regnt",  64'(bus.data_gnt_o), 64'b1000);
    chk("full_outst3", 64'(bus.outst_o),    64'd3);
    cyc(0, 0, 0, 0, 0);
    chk("full_outst4", 64'(bus.outst_o), 64'd4);

    // simultaneous push/pop at outst=2
    cyc(0, 0, 0, 1, 32'h11);
    chk("pp_rv0", 64'(bus.r_valid_o), 64'b0001);
    cyc(0, 0, 0, 1, 32'h22);
    chk("pp_rv1", 64'(bus.r_valid_o), 64'b0010);
    cyc(0, 4'b0010, 1, 1, 32'h33);
    chk("pp_outst_pre", 64'(bus.outst_o),   64'd2);
    chk("pp_gnt",       64'(bus.data_gnt_o), 64'b0010);
    chk("pp_rvalid",    64'(bus.r_valid_o),  64'b0100);
    cyc(0, 0, 0, 0, 0);
    chk("pp_outst", 64'(bus.outst_o), 64'd2);
    cyc(0, 0, 0, 1, 32'h44);
    chk("pp_old", 64'(bus.r_valid_o), 64'b1000);
    cyc(0, 0, 0, 1, 32'h55);
    chk("pp_tail", 64'(bus.r_valid_o), 64'b0010);
    cyc(0, 0, 0, 0, 0);
    chk("pp_empty", 64'(bus.outst_o), 64'h0);

    // underflow
    cyc(0, 0, 0, 1, 32'hDEADBEEF);
    chk("uf_rvalid", 64'(bus.r_valid_o), 64'h0);
    chk("uf_rdata",  64'(bus.r_rdata_o), 64'hDEADBEEF);
    chk("uf_err0",   64'(bus.err_o),     64'h0);
    cyc(0, 0, 0, 0, 0);
    chk("uf_err1",  64'(bus.err_o),   64'h1);
    chk("uf_outst", 64'(bus.outst_o), 64'h0);
    cyc(0, 0, 0, 0, 0);
    chk("uf_sticky", 64'(bus.err_o), 64'h1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("uf_clear", 64'(bus.err_o), 64'h0);

    // reset discards in-flight tracking
    cyc(0, 4'b0001, 1, 0, 0);
    chk("mr_gnt", 64'(bus.data_gnt_o), 64'b0001);
    cyc(1, 0, 0, 0, 0);
    chk("mr_outst_pre", 64'(bus.outst_o), 64'h1);
    cyc(0, 0, 0, 1, 32'h1234);
    chk("mr_outst", 64'(bus.outst_o),   64'h0);
    chk("mr_rv",    64'(bus.r_valid_o), 64'h0);
    cyc(0, 0, 0, 0, 0);
    chk("mr_err", 64'(bus.err_o), 64'h1);
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bridge_rr_arbiter_resp.md
Name: bridge_rr_arbiter_resp

Overview:
- N-channel round-robin request arbiter with in-order response routing for the XBAR bridge.
- Merges N_CH requester channels onto one bridge master port.
- Records the channel index of every granted transaction in an outstanding-transaction FIFO, and steers each returning response (r_valid/r_rdata) to the channel that issued it.
- Generalises the 2-channel request mux to N channels and adds response tracking plus an outstanding-transaction limit.

Parameters:
- N_CH, 4, number of requester channels (>=2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write/read data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, 20, transaction ID width
- MAX_OUTST, 4, outstanding-transaction FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- data_req_i  in  N_CH  per-channel request
- data_add_i  in  N_CH*ADDR_WIDTH  per-channel address, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]; other flattened fields packed the same way
- data_wen_i  in  N_CH  per-channel write-enable (active low = write)
- data_wdata_i  in  N_CH*DATA_WIDTH  write data
- data_be_i  in  N_CH*BE_WIDTH  byte enables
- data_ID_i  in  N_CH*ID_WIDTH  transaction IDs
- data_gnt_o  out  N_CH  per-channel grant
- data_req_o  out  1  merged request to bridge
- data_add_o / data_wen_o / data_wdata_o / data_be_o / data_ID_o  out  ADDR_WIDTH/1/DATA_WIDTH/BE_WIDTH/ID_WIDTH  fields of the winning channel
- data_gnt_i  in  1  bridge grant
- r_valid_i  in  1  response valid from bridge (one per granted transaction, in order)
- r_rdata_i  in  DATA_WIDTH  response data
- r_valid_o  out  N_CH  per-channel response valid
- r_rdata_o  out  DATA_WIDTH  response data broadcast to all channels
- outst_o  out  $clog2(MAX_OUTST+1)  current outstanding count
- err_o  out  1  sticky: response received with no outstanding transaction

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: rr_q=0, FIFO read/write pointers=0, count=0, err_o=0.
- Reset outputs: data_req_o=0 unless a request is present (combinational); data_gnt_o=0; r_valid_o=0; outst_o=0.
- Arbitration (combinational, zero-cycle):
  - winner = first k with data_req_i[k]=1, scanning rr_q, rr_q+1, ..., wrapping mod N_CH.
  - With no request, winner=rr_q.
  - full = (count==MAX_OUTST).
- Request path:
  - data_req_o = (|data_req_i) & ~full.
  - data_*_o = fields of the winner (deterministic even when idle).
  - data_gnt_o[winner] = data_req_o & data_gnt_i; all other grant bits 0.
- Handshake (hs) = data_req_o & data_gnt_i. On hs:
  - rr_q <= (winner+1) mod N_CH.
  - Push winner into FIFO.
  - Without hs, rr_q holds.
- Full: requests are suppressed even if r_valid_i pops in the same cycle. There is no combinational path from r_valid_i to data_req_o; the push resumes the next cycle.
- Response routing (combinational):
  - r_valid_o[head] = r_valid_i & (count!=0); all other bits 0.
  - r_rdata_o = r_rdata_i.
  - Pop on r_valid_i & (count!=0).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push+pop: unchanged.
  - Pointers wrap mod MAX_OUTST.
- Underflow: r_valid_i with count==0 → no r_valid_o, count stays 0, err_o <= 1 (sticky until rst).
- Writes: writes also receive exactly one r_valid_i each and are tracked identically.
- Requester rule: the requester holds req and fields stable until granted. The arbiter does not latch fields.
- Reset mid-operation: all in-flight tracking is discarded. Responses arriving after reset for pre-reset transactions are treated as underflow (err_o=1).
- outst_o = count.

Test Plan:
- Reset: assert rst 2 cycles with data_req_i=4'b1111 → data_gnt_o=0 while data_gnt_i=0, outst_o=0, err_o=0. Then release with data_gnt_i=1 → grants in order ch0, ch1, ch2, ch3 on 4 consecutive cycles.
- Round-robin fairness: data_req_i=4'b1010 held, data_gnt_i=1 → grants alternate ch1, ch3, ch1, ch3. data_add_o matches the granted channel each cycle.
- Backpressure: data_req_i=4'b0100, data_gnt_i=0 for 3 cycles → data_req_o=1, data_gnt_o=0, rr_q unchanged, outst_o=0. data_gnt_i=1 → one grant to ch2, outst_o=1 next cycle.
- Full stall: 4 grants with no response → outst_o=4, data_req_o=0 despite requests. Pulse r_valid_i once → r_valid_o routes to the first granted channel. Same cycle data_req_o stays 0; next cycle a grant issues and outst_o returns to 4.
- Simultaneous push/pop: outst_o=2, hs and r_valid_i in the same cycle → outst_o stays 2. r_valid_o targets the older entry; the new channel is stored at the tail.
- Underflow: outst_o=0, pulse r_valid_i with r_rdata_i=32'hDEADBEEF → r_valid_o=0, err_o=1 next cycle and held. rst → err_o=0.
